// File: rtl/enc4x2_stream.sv
// enc4x2_stream: sequential 4-to-2 encoder.
// Takes a 4-bit request vector through a valid/ready handshake. It then emits
// the 2-bit index {A,B} of every set bit, one code per transfer, in priority
// order, and flags the final code with out_last.
module enc4x2_stream #(
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A,
  output logic             B,
  output logic             out_last,
  output logic             zero_err,
  output logic             busy,
  output logic [CNT_W-1:0] code_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             last_q, last_d;
  logic             zero_err_q, zero_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pend_next;

  // Index of the priority bit. The later match in each loop wins, so the
  // loop direction selects lowest-first or highest-first.
  function automatic logic [1:0] pick(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (LOW_FIRST) begin
      for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
    end else begin
      for (int i = 0; i < 4; i++) if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic single_bit(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Next-state logic: accept a vector in IDLE and step through pend in EMIT.
  // The output code is computed one cycle ahead so that A/B/out_last come from registers.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    last_d      = last_q;
    zero_err_d  = 1'b0;
    cnt_d       = cnt_q;
    pend_next   = pend_q & ~(4'b0001 << {a_q, b_q});
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (D != 4'd0) begin
            pend_d       = D;
            state_d      = EMIT;
            out_valid_d  = 1'b1;
            {a_d, b_d}   = pick(D);
            last_d       = single_bit(D);
          end else begin
            zero_err_d   = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          pend_d = pend_next;
          if (last_q) begin
            state_d     = IDLE;
            pend_d      = 4'd0;
            out_valid_d = 1'b0;
            a_d         = 1'b0;
            b_d         = 1'b0;
            last_d      = 1'b0;
          end else begin
            {a_d, b_d}  = pick(pend_next);
            last_d      = single_bit(pend_next);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 4'd0;
      out_valid_q <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      last_q      <= 1'b0;
      zero_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      zero_err_q  <= zero_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == EMIT);
  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign out_last  = last_q;
  assign zero_err  = zero_err_q;
  assign code_cnt  = cnt_q;

endmodule

// File: doc/enc4x2_stream.md
Name: enc4x2_stream

Overview:
- Sequential 4-to-2 encoder; inverse of the team's 2x4 decoder (index = {A,B}, D[{A,B}] set).
- Accepts a 4-bit request vector D through a valid/ready handshake.
- Emits the 2-bit index of every set bit, one code per handshake, in priority order, with a last flag.
- Sits between request collectors and any consumer that drives a d2x4 decoder from {A,B}.

Parameters:
- LOW_FIRST, 1, 1 = emit lowest set index first (D[0] before D[3]); 0 = highest first.
- CNT_W, 8, width of the emitted-code counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  D is presented.
- in_ready  output  1  block can accept D; high only in IDLE.
- D  input  4  request vector.
- out_valid  output  1  A/B hold a valid code.
- out_ready  input  1  consumer accepts code.
- A  output  1  index MSB.
- B  output  1  index LSB.
- out_last  output  1  current code is the final one for the accepted vector.
- zero_err  output  1  one-cycle pulse: a D==0000 vector was accepted.
- busy  output  1  high in EMIT.
- code_cnt  output  CNT_W  total codes handed off since reset; wraps modulo 2^CNT_W.

Behaviour:
- State set is IDLE and EMIT. Internal register pend[3:0] holds the outstanding bits.
- Reset values (asynchronous):
  - state = IDLE, pend = 0.
  - out_valid = 0, A = 0, B = 0, out_last = 0.
  - zero_err = 0, busy = 0, code_cnt = 0.
  - in_ready = 1 once reset is deasserted.
- Reset asserted mid-burst aborts the burst immediately; remaining bits are discarded.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - If in_valid is high and D != 0 at an edge: pend <= D, state <= EMIT.
  - If in_valid is high and D == 0 at an edge: zero_err = 1 for the next cycle only; state stays IDLE; no code is emitted; code_cnt is unchanged.
- EMIT:
  - in_ready = 0, busy = 1, out_valid = 1.
  - {A,B} = index of the priority bit of pend: lowest set bit if LOW_FIRST = 1, otherwise highest set bit.
  - out_last = 1 iff pend has exactly one bit set.
  - A, B, out_valid and out_last are registered; they are stable while out_valid && !out_ready.
- Handshake:
  - A transfer occurs at an edge where out_valid && out_ready.
  - On a transfer: clear that bit in pend; code_cnt += 1.
  - If out_last was 1: state <= IDLE and out_valid drops in the following cycle.
  - No new D is accepted in the same cycle as the final transfer. in_ready rises the cycle after the final transfer.
- Timing:
  - Latency: D accepted at edge N gives out_valid high after edge N, so the first code is visible in cycle N+1.
  - With out_ready held high, a vector with k set bits takes k cycles in EMIT.
  - Full throughput for back-to-back vectors is k+1 cycles per vector.
- Boundaries:
  - out_ready high while out_valid is low is ignored.
  - in_valid high while in_ready is low is ignored; the source must hold D.
  - code_cnt wraps from 2^CNT_W-1 to 0 without flags.
  - X on D while in_valid is low has no effect.

Test Plan:
- Reset check: assert rst mid-cycle -> all outputs 0 immediately; after release in_ready=1, code_cnt=0.
- Single bit: D=0100 with in_valid for 1 cycle, out_ready=1 -> one transfer A=1,B=0,out_last=1; in_ready high again 2 cycles after acceptance; code_cnt=1.
- Full vector, LOW_FIRST=1: D=1111, out_ready=1 -> codes {A,B}=00,01,10,11 on consecutive cycles; out_last only on 11; code_cnt=4. Same run with LOW_FIRST=0 -> 11,10,01,00.
- Backpressure: D=1010, out_ready=0 for 3 cycles, then 1 -> {A,B}=01 held stable for 3 cycles; then 01 transfers followed by 11 (last); in_ready stays 0 throughout.
- Zero vector: D=0000 accepted -> zero_err=1 for exactly one cycle; out_valid never rises; code_cnt unchanged; in_ready stays 1.
- Reset mid-burst: D=1111, assert rst after 2 transfers -> out_valid=0 at once; code_cnt=0; after release, D=0001 gives a single code 00 with out_last=1.
